// File: rtl/filt_n.sv
// filt_n: N-channel debounce/glitch filter with hysteresis.
// Each channel keeps a registered level and a run counter of consecutive
// ce-sampled values that differ from that level. The level flips once the
// run reaches RISE (asserting) or FALL (deasserting) samples; any matching
// sample cancels the run. rise/fall are one-cycle strobes issued on the
// same edge the level flips.
module filt_n #(
  parameter int   N    = 1,
  parameter int   RISE = 3,
  parameter int   FALL = 3,
  parameter logic INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic [N-1:0] i,
  output logic [N-1:0] y,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int MAX_TH = (RISE > FALL) ? RISE : FALL;
  localparam int CW     = (MAX_TH > 1) ? $clog2(MAX_TH) : 1;

  // Terminal counts: the run counter holds TH-1 when the TH-th differing
  // sample arrives, so the flip happens on that sampling edge.
  localparam logic [CW-1:0] RISE_LAST = CW'(RISE - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL - 1);

  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Next-state: clear beats sample-enable, which beats hold; strobes
  // default low so they last exactly one clock.
  always_comb begin
    y_d    = y_q;
    rise_d = '0;
    fall_d = '0;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (clr) begin
      y_d = {N{INIT}};
      for (int k = 0; k < N; k++) begin
        cnt_d[k] = '0;
      end
    end else if (ce) begin
      for (int k = 0; k < N; k++) begin
        if (i[k] == y_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == (y_q[k] ? FALL_LAST : RISE_LAST)) begin
          y_d[k]    = i[k];
          cnt_d[k]  = '0;
          rise_d[k] = i[k];
          fall_d[k] = ~i[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset to the initial level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= {N{INIT}};
      rise_q <= '0;
      fall_q <= '0;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: doc/filt_n.md
# filt_n

Multi-channel, parametrised debounce/glitch filter with hysteresis. Each of N independent input bits is qualified by a consecutive-sample counter: the filtered output changes only after RISE consecutive sampled 1s (to assert) or FALL consecutive sampled 0s (to deassert). It adds a sample-enable input for prescaled sampling, a synchronous clear, and per-channel one-cycle edge strobes. It sits between raw asynchronous-origin inputs (already synchronised) and control FSMs that consume clean levels and edge events.

## Interface

- N, 1: number of independent channels (≥1).
- RISE, 3: consecutive sampled 1s required to assert a channel output (≥1).
- FALL, 3: consecutive sampled 0s required to deassert a channel output (≥1).
- INIT, 1'b0: value of every y bit after rst or clr.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ce  input  1  sample enable; inputs are sampled and counters advance only on edges where ce=1.
- clr  input  1  synchronous clear; forces the same state as reset.
- i  input  N  raw channel inputs, already synchronised to clk.
- y  output  N  filtered levels, registered.
- rise  output  N  one-clk strobe, bit k high in the cycle after y[k] goes 0→1.
- fall  output  N  one-clk strobe, bit k high in the cycle after y[k] goes 1→0.

## Operation

- Per channel k: registered level y[k] and counter cnt[k], width $clog2(max(RISE,FALL)), minimum 1 bit.
- Reset (rst=1, asynchronous): y=INIT replicated, all cnt=0, rise=0, fall=0. Values hold while rst is high.
- Priority per edge: clr > ce > hold.
- clr=1: y←INIT, cnt←0, rise←0, fall←0, regardless of ce. No strobe is generated even if y changes.
- ce=1, per channel:
  - i[k]==y[k]: cnt[k]←0 (pending change cancelled).
  - i[k]!=y[k] and cnt[k]==TH−1 (TH=RISE if y[k]=0, else FALL): y[k]←i[k], cnt[k]←0, rise[k] or fall[k]←1 per direction.
  - i[k]!=y[k] otherwise: cnt[k]←cnt[k]+1.
- ce=0: y and cnt hold. rise/fall clear to 0 on every edge where they are not newly set.
- A run of differing samples shorter than TH, interrupted by one matching sample, restarts the count from 0. There is no partial credit.
- Channels are fully independent. Simultaneous changes on several bits each follow their own counter.
- rise and fall of the same channel are never high together. The counter never exceeds TH−1.

## Timing

- Latency: y[k] changes on the clk edge that samples the TH-th consecutive differing value (ce=1). With ce tied high, a clean step on i[k] settled before edge n reaches y at edge n+TH−1.
- Strobe: set on the same edge y changes, high for exactly one clk cycle, independent of ce.
- RISE=1 or FALL=1: y follows i on that direction with one-edge latency, no filtering.
- Reset mid-count: the in-progress count is discarded. After release, a full TH samples are required.
- ce rate sets the time base. Input changes between ce edges are invisible.

## Test plan

- N=4, RISE=3, FALL=3, ce=1: i[0] 0→1 held. Required: y[0]=1 after the 3rd sampling edge; rise[0]=1 for exactly 1 cycle; y[3:1]=0; rise[3:1] and fall stay 0. Then i[0]→0 held: y[0]=0 after 3 edges, one-cycle fall[0].
- Glitch rejection (RISE=3): i[1]=1 for 2 cycles then 0, repeated 5 times. Required: y[1]=0 throughout, no strobes. A final 1 held 3 cycles then asserts y[1].
- Asymmetric (RISE=2, FALL=5), y[2]=1: 4 zeros, one 1, then 5 zeros. Required: y[2] stays 1 through the first 4 zeros; it drops only on the 5th zero of the second run; one fall[2] pulse.
- ce prescale (ce high 1 in 4 clk, RISE=3): i toggles between ce pulses and is stable only at ce edges. Required: y follows the ce-sampled values only, asserting 3 ce pulses (≈12 clk) after a stable 1; each strobe lasts 1 clk, not 4.
- rst asserted asynchronously mid-count with cnt=2, INIT=0: y, rise and fall go 0 immediately, not waiting for a clk edge. After release, 3 fresh samples are required. Also drive clr=1 with ce=1 while y=1: y=INIT next edge, no fall strobe.
- RISE=FALL=1, N=8: random i with ce=1. Required: y equals i delayed one edge; rise equals (y & ~y_prev) and fall equals (~y & y_prev), each delayed as specified.
